// File: rtl/fp16_accum_seq.sv
// Streaming sum-reduction sequencer for a pipelined FP adder: interleaves ADD_LAT partial
// sums to hide adder latency, then folds them in fixed order into one sum per packet.
module fp16_accum_seq #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam int CW = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_slot [ADD_LAT];
    logic [PW-1:0]     r_p;
    logic [ADD_LAT-1:0] r_pipe_v;
    logic [PW-1:0]     r_pipe_tag [ADD_LAT];
    logic [PW-1:0]     r_k;
    logic [CW-1:0]     r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;

    logic              w_accept;
    logic              w_ret_v;
    logic [PW-1:0]     w_ret_tag;
    logic              w_bypass;
    logic              w_drain_busy;
    logic              w_red_issue;
    logic [WIDTH-1:0]  w_add_a;
    logic [WIDTH-1:0]  w_add_b;

    assign w_accept     = in_valid & r_in_ready & (r_state == ST_ACCUM);
    assign w_ret_v      = r_pipe_v[ADD_LAT-1];
    assign w_ret_tag    = r_pipe_tag[ADD_LAT-1];
    assign w_bypass     = w_ret_v & (w_ret_tag == r_p);
    // The oldest stage may still be valid: its result is written this very cycle.
    assign w_drain_busy = |r_pipe_v[ADD_LAT-2:0];
    assign w_red_issue  = (r_state == ST_REDUCE) & (r_cnt == CW'(0));

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;

    // Adder operand select: accumulate issue, reduce issue, or +0 when idle.
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        if (w_accept) begin
            w_add_a = w_bypass ? add_result : r_slot[r_p];
            w_add_b = in_data;
        end else if (w_red_issue) begin
            w_add_a = r_slot[0];
            w_add_b = r_slot[r_k];
        end else begin
            w_add_a = '0;
            w_add_b = '0;
        end
    end

    // Sequencer state, partial-sum slots, in-flight tag pipe and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_p         <= '0;
            r_pipe_v    <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                r_slot[i]     <= '0;
                r_pipe_tag[i] <= '0;
            end
        end else begin
            r_pipe_v      <= {r_pipe_v[ADD_LAT-2:0], w_accept};
            r_pipe_tag[0] <= r_p;
            for (int i = 1; i < ADD_LAT; i++) begin
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            if (w_ret_v) begin
                r_slot[w_ret_tag] <= add_result;
            end

            case (r_state)
                ST_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_p <= (r_p == PW'(ADD_LAT - 1)) ? '0 : r_p + PW'(1);
                        if (in_last) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_drain_busy) begin
                        r_state <= ST_REDUCE;
                        r_k     <= PW'(1);
                        r_cnt   <= '0;
                    end
                end
                ST_REDUCE: begin
                    if (r_cnt == CW'(ADD_LAT)) begin
                        r_cnt <= '0;
                        if (r_k == PW'(ADD_LAT - 1)) begin
                            r_out_data  <= add_result;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_slot[0] <= add_result;
                            r_k       <= r_k + PW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_p         <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACCUM;
                        for (int i = 0; i < ADD_LAT; i++) begin
                            r_slot[i] <= '0;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_ACCUM;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
